// File: rtl/kmer_classify_ctrl.sv
// Sequencer for the k-mer classification compare datapath.
// Moore FSM: every output decodes from the registered state; kmer_cnt/err are side registers.
module kmer_classify_ctrl #(
    parameter int NUM_KMERS   = 208,
    parameter int SRAM_RD_LAT = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       map_full,
    input  logic       result_ready,
    input  logic       update_map_done,
    output logic       EN_POS,
    output logic       EN_CLASS,
    output logic       Read_sram,
    output logic       EN_COMPARE,
    output logic       local_min,
    output logic       calc_absolute,
    output logic       get_result,
    output logic       res_to_map,
    output logic       EN_EC,
    output logic       WEB2,
    output logic       OEB2,
    output logic       CSB2,
    output logic       WEB2_ba,
    output logic       OEB2_ba,
    output logic       CSB2_ba,
    output logic [7:0] kmer_cnt,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE, S_POS, S_BA_RD, S_CLASS, S_RD, S_CNT, S_LMIN, S_ABS,
        S_RES, S_WAIT_RDY, S_MAP, S_WAIT_UPD, S_DONE
    } state_t;

    localparam logic [7:0] LAT_LAST   = 8'(SRAM_RD_LAT - 1);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [7:0] KMER_LAST  = 8'(NUM_KMERS - 1);

    state_t     r_state, w_next;
    logic [7:0] r_wait;
    logic [7:0] r_kmer;
    logic       r_err;
    logic       w_inc, w_clr, w_set_err;

    // r_wait restarts at 0 on every state entry; it serves both the read latency and the timeouts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wait  <= 8'd0;
            r_kmer  <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_next != r_state) ? 8'd0 : r_wait + 8'd1;
            if (w_clr)
                r_kmer <= 8'd0;
            else if (w_inc)
                r_kmer <= r_kmer + 8'd1;
            if (w_clr)
                r_err <= 1'b0;
            else if (w_set_err)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_inc         = 1'b0;
        w_clr         = 1'b0;
        w_set_err     = 1'b0;
        EN_POS        = 1'b0;
        EN_CLASS      = 1'b0;
        Read_sram     = 1'b0;
        EN_COMPARE    = 1'b0;
        local_min     = 1'b0;
        calc_absolute = 1'b0;
        get_result    = 1'b0;
        res_to_map    = 1'b0;
        OEB2          = 1'b1;
        CSB2          = 1'b1;
        OEB2_ba       = 1'b1;
        CSB2_ba       = 1'b1;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = S_POS;
                end
            end
            S_POS: begin
                EN_POS = 1'b1;
                w_next = S_BA_RD;
            end
            S_BA_RD: begin
                CSB2_ba = 1'b0;
                OEB2_ba = 1'b0;
                if (r_wait == LAT_LAST) w_next = S_CLASS;
            end
            S_CLASS: begin
                EN_CLASS = 1'b1;
                CSB2_ba  = 1'b0;
                OEB2_ba  = 1'b0;
                w_next   = S_RD;
            end
            S_RD: begin
                CSB2 = 1'b0;
                OEB2 = 1'b0;
                if (r_wait == LAT_LAST) w_next = S_CNT;
            end
            S_CNT: begin
                Read_sram = 1'b1;
                CSB2      = 1'b0;
                OEB2      = 1'b0;
                w_next    = S_LMIN;
            end
            S_LMIN: begin
                EN_COMPARE = 1'b1;
                local_min  = 1'b1;
                w_next     = S_ABS;
            end
            S_ABS: begin
                EN_COMPARE    = 1'b1;
                calc_absolute = 1'b1;
                w_next        = S_RES;
            end
            S_RES: begin
                EN_COMPARE = 1'b1;
                get_result = 1'b1;
                w_next     = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (result_ready) begin
                    w_next = S_MAP;
                end else if (r_wait == TO_LAST) begin
                    w_set_err = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_MAP: begin
                res_to_map = 1'b1;
                w_next     = S_WAIT_UPD;
            end
            S_WAIT_UPD: begin
                if (update_map_done) begin
                    if (r_kmer == KMER_LAST || map_full) begin
                        w_next = S_DONE;
                    end else begin
                        w_inc  = 1'b1;
                        w_next = S_POS;
                    end
                end else if (r_wait == TO_LAST) begin
                    w_set_err = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // abort overrides everything but leaves kmer_cnt/err untouched
        if (abort) begin
            w_next    = S_IDLE;
            w_inc     = 1'b0;
            w_clr     = 1'b0;
            w_set_err = 1'b0;
        end
    end

    assign EN_EC    = 1'b0;
    assign WEB2     = 1'b1;
    assign WEB2_ba  = 1'b1;
    assign kmer_cnt = r_kmer;
    assign err      = r_err;

endmodule

// File: tb/tb_kmer_classify_ctrl.sv
// Directed bench for kmer_classify_ctrl: one default instance (A) and one with
// SRAM_RD_LAT=3, NUM_KMERS=4 (B); per-cycle output vectors checked against a phase table.
module tb_kmer_classify_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, start_b = 1'b0, abort = 1'b0;
    logic map_full = 1'b0, result_ready = 1'b1, update_map_done = 1'b1;

    logic a_pos, a_cls, a_rds, a_cmp, a_lmin, a_abs, a_res, a_r2m, a_ec;
    logic a_web, a_oeb, a_csb, a_webba, a_oebba, a_csbba, a_busy, a_done, a_err;
    logic [7:0] a_kmer;
    logic b_pos, b_cls, b_rds, b_cmp, b_lmin, b_abs, b_res, b_r2m, b_ec;
    logic b_web, b_oeb, b_csb, b_webba, b_oebba, b_csbba, b_busy, b_done, b_err;
    logic [7:0] b_kmer;

    kmer_classify_ctrl u_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .map_full(map_full),
        .result_ready(result_ready), .update_map_done(update_map_done),
        .EN_POS(a_pos), .EN_CLASS(a_cls), .Read_sram(a_rds), .EN_COMPARE(a_cmp),
        .local_min(a_lmin), .calc_absolute(a_abs), .get_result(a_res), .res_to_map(a_r2m),
        .EN_EC(a_ec), .WEB2(a_web), .OEB2(a_oeb), .CSB2(a_csb),
        .WEB2_ba(a_webba), .OEB2_ba(a_oebba), .CSB2_ba(a_csbba),
        .kmer_cnt(a_kmer), .busy(a_busy), .done(a_done), .err(a_err)
    );

    kmer_classify_ctrl #(.NUM_KMERS(4), .SRAM_RD_LAT(3), .TIMEOUT(15)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(1'b0), .map_full(map_full),
        .result_ready(result_ready), .update_map_done(update_map_done),
        .EN_POS(b_pos), .EN_CLASS(b_cls), .Read_sram(b_rds), .EN_COMPARE(b_cmp),
        .local_min(b_lmin), .calc_absolute(b_abs), .get_result(b_res), .res_to_map(b_r2m),
        .EN_EC(b_ec), .WEB2(b_web), .OEB2(b_oeb), .CSB2(b_csb),
        .WEB2_ba(b_webba), .OEB2_ba(b_oebba), .CSB2_ba(b_csbba),
        .kmer_cnt(b_kmer), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    logic [31:0] outs_a, outs_b;
    assign outs_a = {14'd0, a_pos, a_cls, a_rds, a_cmp, a_lmin, a_abs, a_res, a_r2m, a_ec,
                     a_web, a_oeb, a_csb, a_webba, a_oebba, a_csbba, a_busy, a_done, a_err};
    assign outs_b = {14'd0, b_pos, b_cls, b_rds, b_cmp, b_lmin, b_abs, b_res, b_r2m, b_ec,
                     b_web, b_oeb, b_csb, b_webba, b_oebba, b_csbba, b_busy, b_done, b_err};

    // bit 8..3 = WEB2,OEB2,CSB2,WEB2_ba,OEB2_ba,CSB2_ba; 2 busy; 1 done; 0 err
    localparam logic [31:0] IDLE_V = 32'h1F8;
    localparam logic [31:0] DONE_V = 32'h1FA;
    localparam int P_POS = 0, P_BA = 1, P_CLASS = 2, P_RD = 3, P_CNT = 4, P_LMIN = 5;
    localparam int P_ABS = 6, P_RES = 7, P_WRDY = 8, P_MAP = 9, P_WUPD = 10;

    int n_vec = 0, n_bad = 0;
    int sel = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_vec(input int ph);
        logic [31:0] v;
        v = 32'h1FC;
        case (ph)
            P_POS:   v[17] = 1'b1;
            P_BA:    begin v[4] = 1'b0; v[3] = 1'b0; end
            P_CLASS: begin v[16] = 1'b1; v[4] = 1'b0; v[3] = 1'b0; end
            P_RD:    begin v[7] = 1'b0; v[6] = 1'b0; end
            P_CNT:   begin v[15] = 1'b1; v[7] = 1'b0; v[6] = 1'b0; end
            P_LMIN:  begin v[14] = 1'b1; v[13] = 1'b1; end
            P_ABS:   begin v[14] = 1'b1; v[12] = 1'b1; end
            P_RES:   begin v[14] = 1'b1; v[11] = 1'b1; end
            P_MAP:   v[10] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] outs();
        return (sel != 0) ? outs_b : outs_a;
    endfunction

    function automatic logic [31:0] kcnt();
        return (sel != 0) ? 32'(b_kmer) : 32'(a_kmer);
    endfunction

    task automatic kick();
        if (sel != 0) start_b = 1'b1; else start = 1'b1;
        tick();
        start   = 1'b0;
        start_b = 1'b0;
    endtask

    // Walks nslots slots from the first POS cycle; slot 0 checked per cycle, the rest tallied.
    task automatic walk(input int lat, input int nslots, output int pulses, output int bad);
        int seq[$];
        logic [31:0] o, e;
        pulses = 0;
        bad    = 0;
        seq.push_back(P_POS);
        for (int i = 0; i < lat; i++) seq.push_back(P_BA);
        seq.push_back(P_CLASS);
        for (int i = 0; i < lat; i++) seq.push_back(P_RD);
        seq.push_back(P_CNT);  seq.push_back(P_LMIN); seq.push_back(P_ABS);
        seq.push_back(P_RES);  seq.push_back(P_WRDY); seq.push_back(P_MAP);
        seq.push_back(P_WUPD);
        for (int s = 0; s < nslots; s++) begin
            for (int i = 0; i < seq.size(); i++) begin
                o = outs();
                e = exp_vec(seq[i]);
                if (s == 0)
                    chk($sformatf("seq%0d_%0d", sel, i), o, e);
                else if (o !== e || kcnt() !== 32'(s))
                    bad++;
                if (o[10]) pulses++;
                tick();
            end
        end
    endtask

    initial begin
        int p, b, cyc;
        repeat (2) tick();
        chk("rst_outs_a", outs_a, IDLE_V);
        chk("rst_outs_b", outs_b, IDLE_V);
        chk("rst_kmer", 32'(a_kmer), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_hold", outs_a, IDLE_V);

        // nominal full run
        sel = 0;
        kick();
        walk(1, 208, p, b);
        chk("nom_seq_bad", 32'(b), 32'd0);
        chk("nom_r2m", 32'(p), 32'd208);
        chk("nom_done", outs_a, DONE_V);
        chk("nom_kmer", 32'(a_kmer), 32'd207);
        tick();
        chk("nom_idle", outs_a, IDLE_V);

        // early stop via map_full in slot 5
        kick();
        cyc = 0;
        p   = 0;
        while (cyc < 300 && !a_done) begin
            if (a_r2m) p++;
            if (a_kmer == 8'd5) map_full = 1'b1;
            tick();
            cyc++;
        end
        map_full = 1'b0;
        chk("es_cyc", 32'(cyc), 32'd66);
        chk("es_r2m", 32'(p), 32'd6);
        chk("es_kmer", 32'(a_kmer), 32'd5);
        start = 1'b1;
        repeat (3) tick();
        chk("done_hold", outs_a, DONE_V);
        start = 1'b0;
        tick();
        chk("es_idle", outs_a, IDLE_V);

        // timeout on result_ready at slot 0
        result_ready = 1'b0;
        kick();
        repeat (22) tick();
        chk("to_wait", outs_a, exp_vec(P_WRDY));
        tick();
        chk("to_done", outs_a, DONE_V | 32'h1);
        chk("to_kmer", 32'(a_kmer), 32'd0);
        tick();
        chk("to_idle_err", outs_a, IDLE_V | 32'h1);
        result_ready = 1'b1;
        kick();
        chk("err_clr", outs_a, exp_vec(P_POS));

        // abort during slot 1 ABS
        repeat (17) tick();
        chk("ab_abs", outs_a, exp_vec(P_ABS));
        chk("ab_kmer_pre", 32'(a_kmer), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle", outs_a, IDLE_V);
        chk("ab_kmer_hold", 32'(a_kmer), 32'd1);

        // async reset during slot 1 RD
        kick();
        repeat (14) tick();
        chk("rs_rd", outs_a, exp_vec(P_RD));
        #2 reset = 1'b1;
        #1;
        chk("rs_async", outs_a, IDLE_V);
        chk("rs_kmer", 32'(a_kmer), 32'd0);
        reset = 1'b0;
        tick();

        // SRAM_RD_LAT=3 instance, 4 slots of 15 cycles
        sel = 1;
        kick();
        walk(3, 4, p, b);
        chk("lat3_seq_bad", 32'(b), 32'd0);
        chk("lat3_r2m", 32'(p), 32'd4);
        chk("lat3_done", outs_b, DONE_V);
        chk("lat3_kmer", 32'(b_kmer), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/kmer_classify_ctrl.md
# kmer_classify_ctrl

Sequencer for the k-mer classification compare datapath. On `start`, it walks every k-mer slot of the map in order. For each slot it issues the position-update, bit-array read, classification, counter-SRAM read, three-step compare, and map-write enables, each in its required order. It also drives the port-2 read controls of both SRAM groups and handshakes on the datapath's `result_ready` and `update_map_done` flags.

## Interface
Parameters:
- `NUM_KMERS`, 208: k-mer slots per run; last slot index is `NUM_KMERS-1`.
- `SRAM_RD_LAT`, 1: cycles that CSB/OEB are held low before data is captured (1..7).
- `TIMEOUT`, 15: maximum cycles spent in any handshake wait state (1..255).

Ports:
- `clk` in 1: clock. One clock domain; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; level-sampled in IDLE and DONE.
- `abort` in 1: synchronous abort back to IDLE.
- `map_full` in 1: datapath reports the map is complete.
- `result_ready` in 1: compare result is valid.
- `update_map_done` in 1: map write is acknowledged.
- `EN_POS`, `EN_CLASS`, `Read_sram`, `EN_COMPARE`, `local_min`, `calc_absolute`, `get_result`, `res_to_map` out 1 each: datapath enables.
- `EN_EC` out 1: tied 0; error correction is not sequenced here.
- `WEB2`, `OEB2`, `CSB2` out 1 each: counter SRAM read port controls.
- `WEB2_ba`, `OEB2_ba`, `CSB2_ba` out 1 each: bit-array SRAM read port controls.
- `kmer_cnt` out 8: index of the slot currently being processed.
- `busy` out 1: a run is in progress.
- `done` out 1: the run has finished.
- `err` out 1: a handshake wait timed out during this run.

## Operation
- Moore FSM. All outputs decode from the registered state; there are no combinational paths from inputs to outputs.
- Reset values and IDLE values: all enables 0, `EN_EC` 0, all WEB/OEB/CSB 1, `kmer_cnt` 0, `busy` 0, `done` 0, `err` 0.
- IDLE: on `start`=1, clear `kmer_cnt` and `err`, then go to POS.
- POS: `EN_POS`=1 for one cycle. Go to BA_RD.
- BA_RD: `CSB2_ba`=`OEB2_ba`=0 for `SRAM_RD_LAT` cycles, counted by a wait counter. Go to CLASS.
- CLASS: `EN_CLASS`=1, bit-array read still asserted, one cycle. Go to RD.
- RD: `CSB2`=`OEB2`=0 for `SRAM_RD_LAT` cycles. Go to CNT.
- CNT: `Read_sram`=1, `CSB2`/`OEB2` still 0, one cycle. Go to LMIN.
- LMIN, ABS, RES: `EN_COMPARE`=1 in each, plus `local_min`, `calc_absolute`, `get_result` respectively. One cycle each, in that order. At most one of the three sub-enables is ever high.
- WAIT_RDY: hold until `result_ready`=1, then go to MAP.
- MAP: `res_to_map`=1 for one cycle. Go to WAIT_UPD.
- WAIT_UPD: hold until `update_map_done`=1. Then:
  - if `kmer_cnt`==`NUM_KMERS-1` or `map_full`=1, go to DONE;
  - otherwise increment `kmer_cnt` and go to POS.
- DONE: `done`=1, `busy`=0. Stay while `start`=1. When `start`=0, go to IDLE; `done` drops and `err` holds its value.
- Timeout: each wait state counts cycles from entry. On reaching `TIMEOUT` without the expected flag, set `err`=1 and go to DONE.
- `busy`=1 in every state except IDLE and DONE. `start` is ignored while `busy`=1.
- `WEB2` and `WEB2_ba` are constant 1; this block never writes either SRAM.

## Timing
- Per k-mer with `SRAM_RD_LAT`=1 and flags arriving on the first wait cycle: 11 cycles (POS, BA_RD, CLASS, RD, CNT, LMIN, ABS, RES, WAIT_RDY, MAP, WAIT_UPD).
- Full run of 208 slots: 2288 cycles from the first POS cycle to DONE entry.
- `start` high in IDLE at edge N: POS is active in cycle N+1.
- Flag sampled high at edge M in a wait state: the next state is active in cycle M+1.
- `map_full` is sampled only in WAIT_UPD.
- `abort`=1 at any edge: IDLE in the next cycle with all reset values, except `kmer_cnt` and `err`, which hold. `abort` takes priority over every transition.
- Reset asserted mid-run: asynchronous return to IDLE with all reset values. No enable may stay high after reset rises.
- `kmer_cnt` is 8 bits wide and never wraps: the run stops at `NUM_KMERS-1`.

## Test plan
- Nominal run: `start` pulse, datapath model answers each flag on the first wait cycle → exactly 208 `res_to_map` pulses, `done` at cycle 2288 after POS, `err`=0, `kmer_cnt`=207.
- Ordering check: per slot the enable sequence is EN_POS, EN_CLASS, Read_sram, local_min, calc_absolute, get_result, res_to_map, each 1 cycle wide → no overlaps; `CSB2_ba` low only in BA_RD and CLASS; `CSB2` low only in RD and CNT.
- Early stop: `map_full`=1 during slot 5 WAIT_UPD → DONE next cycle, 6 map writes total.
- Timeout: `result_ready` withheld at slot 0 → `err`=1 and DONE after 15 WAIT_RDY cycles; `start` low → IDLE with `err` still 1; next `start` clears it.
- `SRAM_RD_LAT`=3 → BA_RD and RD each hold 3 cycles; per-slot time becomes 15 cycles.
- Abort/reset: `abort` during ABS → IDLE next cycle with enables 0; async `reset` pulse during RD → outputs return to reset values before the next `clk` edge.
